// File: rtl/instruction_decode_pkg.sv
// instruction_decode_pkg: RV64 opcode constants, bubble encoding and immediate-format classification.
package instruction_decode_pkg;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_IMM32  = 7'b0011011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  function automatic imm_type_e imm_type(input logic [6:0] op);
    return (op inside {OP_LOAD, OP_IMM, OP_IMM32, OP_JALR}) ? IMM_I :
           (op == OP_STORE)                 ? IMM_S :
           (op == OP_BRANCH)                ? IMM_B :
           (op inside {OP_LUI, OP_AUIPC})   ? IMM_U :
           (op == OP_JAL)                   ? IMM_J : IMM_NONE;
  endfunction

  // R-type carries no immediate but is still a supported opcode
  function automatic logic op_known(input logic [6:0] op);
    return (imm_type(op) != IMM_NONE) || (op == OP_REG) || (op == OP_REG32);
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational sign-extended immediate extraction for the RV64 base formats.
module imm_gen
  import instruction_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm_data
);
  imm_type_e w_type;
  logic [31:0] w_i;

  assign w_i    = instruction;
  assign w_type = imm_type(w_i[6:0]);

  always_comb begin
    imm_data = '0;
    imm_data = (w_type == IMM_I) ? {{(XLEN-12){w_i[31]}}, w_i[31:20]} :
               (w_type == IMM_S) ? {{(XLEN-12){w_i[31]}}, w_i[31:25], w_i[11:7]} :
               (w_type == IMM_B) ? {{(XLEN-13){w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0} :
               (w_type == IMM_U) ? {{(XLEN-32){w_i[31]}}, w_i[31:12], 12'b0} :
               (w_type == IMM_J) ? {{(XLEN-21){w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0} :
                                   '0;
  end
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: IF/ID pipeline register with stall/flush control, field split, immediate and illegal check.
module instruction_decode #(
  parameter int          XLEN     = 64,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction_if,
  input  logic [XLEN-1:0] pc_if,
  input  logic            valid_if,
  input  logic            stall,
  input  logic            flush,
  output logic            ready_id,
  output logic            valid_id,
  output logic [XLEN-1:0] pc_id,
  output logic [31:0]     instruction_id,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm_data,
  output logic            illegal
);
  import instruction_decode_pkg::op_known;

  logic            r_valid;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_pc;

  // Invalid fetch slots become bubbles so downstream never sees stale data
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= '0;
    end else if (!stall) begin
      r_valid <= valid_if;
      r_inst  <= valid_if ? instruction_if : NOP_INST;
      r_pc    <= valid_if ? pc_if : '0;
    end
  end

  assign ready_id       = !stall;
  assign valid_id       = r_valid;
  assign pc_id          = r_pc;
  assign instruction_id = r_inst;
  assign opcode         = r_inst[6:0];
  assign rd             = r_inst[11:7];
  assign funct3         = r_inst[14:12];
  assign rs1            = r_inst[19:15];
  assign rs2            = r_inst[24:20];
  assign funct7         = r_inst[31:25];
  assign illegal        = r_valid && ((r_inst[1:0] != 2'b11) || !op_known(r_inst[6:0]));

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction (r_inst),
    .imm_data    (imm_data)
  );
endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameters SHALL be: XLEN, 64, datapath/PC width; NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 instruction_if  input  32  fetched instruction from the fetch stage.
REQ-005 pc_if  input  XLEN  address of instruction_if.
REQ-006 valid_if  input  1  instruction_if/pc_if carry a real instruction this cycle.
REQ-007 stall  input  1  hold the decode register (hazard from downstream).
REQ-008 flush  input  1  discard the held and incoming instruction (redirect).
REQ-009 ready_id  output  1  decode register accepts new input this cycle.
REQ-010 valid_id  output  1  decode outputs are a real instruction.
REQ-011 pc_id  output  XLEN  registered PC.
REQ-012 instruction_id  output  32  registered instruction.
REQ-013 opcode, rd, funct3, rs1, rs2, funct7  output  7/5/3/5/5/7  fields instruction_id[6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
REQ-014 imm_data  output  XLEN  sign-extended immediate.
REQ-015 illegal  output  1  valid_id high and the instruction is unsupported.

Function
REQ-016 ready_id SHALL equal !stall, combinationally; latency input-to-output SHALL be one clock.
REQ-017 Per edge, priority SHALL be reset > flush > stall > load.
REQ-018 flush=1: valid_id<=0, instruction_id<=NOP_INST, pc_id<=0, regardless of stall or valid_if.
REQ-019 stall=1, flush=0: all registers SHALL hold; input is not consumed.
REQ-020 load: if valid_if=1, capture instruction_if/pc_if and set valid_id=1; if valid_if=0, insert bubble (NOP_INST, pc 0, valid_id=0).
REQ-021 Field outputs and imm_data SHALL be combinational from instruction_id only.
REQ-022 I-type (opcodes 0000011, 0010011, 0011011, 1100111): imm = sext(inst[31:20]).
REQ-023 S-type (0100011): imm = sext({inst[31:25],inst[11:7]}).
REQ-024 B-type (1100011): imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
REQ-025 U-type (0110111, 0010111): imm = sext({inst[31:12],12'b0}).
REQ-026 J-type (1101111): imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-027 R-type (0110011, 0111011) and any other opcode: imm = 0.
REQ-028 illegal SHALL be 1 iff valid_id=1 and (inst[1:0]!=2'b11 or opcode not in REQ-022..027 set); never 1 for a bubble.

Reset
REQ-029 While reset=1 at an edge: valid_id=0, instruction_id=NOP_INST, pc_id=0; hence fields decode NOP, imm_data=0, illegal=0.
REQ-030 Reset mid-stall SHALL discard the held instruction; first capture occurs on the first edge with reset=0, flush=0, stall=0.

Structure
REQ-031 Shared package SHALL hold opcode constants, NOP_INST, and the immediate-type enum (I,S,B,U,J,NONE).
REQ-032 Immediate generation SHALL be one combinational sub-module, imm_gen (instruction in, imm_data out); the register, stall/flush control and illegal check live in instruction_decode.

Verification
REQ-033 valid_if=1, instruction_if=0x00500093, pc_if=0x10 -> next cycle valid_id=1, pc_id=0x10, opcode=0010011, rd=1, rs1=0, imm_data=5, illegal=0.
REQ-034 instruction_if=0xFF813283 (ld x5,-8(x2)) -> imm_data=0xFFFFFFFFFFFFFFF8, rd=5, rs1=2, funct3=3; then 0x00513823 (sd x5,16(x2)) -> imm_data=16, rs2=5.
REQ-035 instruction_if=0xFE208EE3 (beq x1,x2,-4) -> imm_data=0xFFFFFFFFFFFFFFFC, rs1=1, rs2=2.
REQ-036 Load 0x00500093, then stall=1 for 3 cycles with changing instruction_if -> instruction_id stays 0x00500093, ready_id=0; stall=1 and flush=1 together -> next cycle valid_id=0, instruction_id=0x00000013.
REQ-037 instruction_if=0xFFFFFFFF valid_if=1 -> illegal=1; valid_if=0 -> bubble, illegal=0.
REQ-038 reset=1 asserted while stalled with a valid instruction held -> next cycle valid_id=0, pc_id=0, instruction_id=0x00000013.
